// File: rtl/x_moment.sv
// Streaming x-moment engine: signed x-weighted sum of column sums over a sliding
// window of accepted columns, six accepted columns of pipeline latency.
module x_moment #(
  parameter  int LUMA_BITS     = 8,
  parameter  int WINDOW_SIZE_X = 7,
  parameter  int WINDOW_SIZE_Y = 5,
  localparam int HALF_WIDTH    = WINDOW_SIZE_X / 2,
  localparam int MOMENT_BITS   =
    $clog2(HALF_WIDTH * (HALF_WIDTH + 1) * WINDOW_SIZE_Y / 2) + LUMA_BITS + 1
) (
  input  logic                          clk,
  input  logic                          in_reset,
  input  logic                          in_valid,
  input  logic [LUMA_BITS-1:0]          in_column [WINDOW_SIZE_Y],
  output logic signed [MOMENT_BITS-1:0] out_xmoment,
  output logic                          out_valid
);

  localparam int          SUM_BITS = LUMA_BITS + $clog2(WINDOW_SIZE_Y + 1);
  localparam int unsigned YL       = WINDOW_SIZE_Y / 2;
  localparam int unsigned LAT      = 6;

  logic [SUM_BITS-1:0]           part_q [2];
  logic [SUM_BITS-1:0]           part_d [2];
  logic [SUM_BITS-1:0]           sum_q, sum_d;
  logic [SUM_BITS-1:0]           win_q  [WINDOW_SIZE_X];
  logic [SUM_BITS-1:0]           win_d  [WINDOW_SIZE_X];
  logic signed [MOMENT_BITS-1:0] diff_q [HALF_WIDTH];
  logic signed [MOMENT_BITS-1:0] diff_d [HALF_WIDTH];
  logic signed [MOMENT_BITS-1:0] wt_q   [HALF_WIDTH];
  logic signed [MOMENT_BITS-1:0] wt_d   [HALF_WIDTH];
  logic signed [MOMENT_BITS-1:0] tot_q, tot_d;
  logic signed [MOMENT_BITS-1:0] out_q;
  logic                          valid_q;
  logic [2:0]                    cnt_q;

  // Two-level column adder tree: half-column partials, then their total.
  always_comb begin
    part_d = '{default: '0};
    for (int unsigned i = 0; i < WINDOW_SIZE_Y; i++) begin
      if (i < YL) part_d[0] = part_d[0] + SUM_BITS'(in_column[i]);
      else        part_d[1] = part_d[1] + SUM_BITS'(in_column[i]);
    end
    sum_d = part_q[0] + part_q[1];
  end

  // win_q[0] is the newest sum; win_q[HALF_WIDTH] is the zero-weight centre.
  always_comb begin
    win_d[0] = sum_q;
    for (int unsigned i = 1; i < WINDOW_SIZE_X; i++) win_d[i] = win_q[i-1];
    for (int unsigned d = 0; d < HALF_WIDTH; d++) begin
      diff_d[d] = MOMENT_BITS'(win_q[HALF_WIDTH-1-d]) - MOMENT_BITS'(win_q[HALF_WIDTH+1+d]);
      wt_d[d]   = diff_q[d] * $signed(MOMENT_BITS'(d + 1));
    end
    tot_d = '0;
    for (int unsigned d = 0; d < HALF_WIDTH; d++) tot_d = tot_d + wt_q[d];
  end

  always_ff @(posedge clk) begin
    if (!in_reset) begin
      if (in_valid) part_q <= part_d;
      else          part_q <= '{default: '0};
      sum_q   <= '0;
      win_q   <= '{default: '0};
      diff_q  <= '{default: '0};
      wt_q    <= '{default: '0};
      tot_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= in_valid ? 3'd1 : 3'd0;
    end else if (in_valid) begin
      part_q  <= part_d;
      sum_q   <= sum_d;
      win_q   <= win_d;
      diff_q  <= diff_d;
      wt_q    <= wt_d;
      tot_q   <= tot_d;
      out_q   <= tot_q;
      // cnt_q saturates once the pipeline holds only post-reset data.
      valid_q <= (cnt_q == 3'(LAT));
      if (cnt_q != 3'(LAT)) cnt_q <= cnt_q + 3'd1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign out_xmoment = out_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_x_moment.sv
// Directed and randomized bench for x_moment, checked against a moment model
// computed directly from the history of accepted column sums.
module tb_x_moment;

  localparam int MB = 14;
  typedef logic [7:0] col_t [5];

  logic                 clk = 1'b0;
  logic                 in_reset;
  logic                 in_valid;
  col_t                 in_column;
  logic signed [MB-1:0] out_xmoment;
  logic                 out_valid;

  int tests = 0;
  int fails = 0;

  int hist[$];
  logic signed [MB-1:0] exp_out = '0;
  logic                 exp_v   = 1'b0;

  x_moment #(.LUMA_BITS(8), .WINDOW_SIZE_X(7), .WINDOW_SIZE_Y(5)) dut (
    .clk(clk), .in_reset(in_reset), .in_valid(in_valid), .in_column(in_column),
    .out_xmoment(out_xmoment), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic int s_at(int j);
    if (j < 0 || j >= hist.size()) return 0;
    return hist[j];
  endfunction

  function automatic int moment(int k);
    int m = 0;
    for (int d = 1; d <= 3; d++) m += d * (s_at(k - 3 + d) - s_at(k - 3 - d));
    return m;
  endfunction

  function automatic col_t mk_col(int s);
    col_t c;
    int rem = s;
    for (int i = 0; i < 5; i++) begin
      c[i] = (rem > 255) ? 8'd255 : 8'(rem);
      rem -= int'(c[i]);
    end
    return c;
  endfunction

  function automatic col_t rnd_col();
    col_t c;
    bit full = ($urandom_range(0, 4) == 0);
    for (int i = 0; i < 5; i++) c[i] = full ? 8'hFF : 8'($urandom_range(0, 255));
    return c;
  endfunction

  task automatic step(input bit rst_n, input bit v, input col_t c, input string tag);
    int s = 0;
    in_reset  = rst_n;
    in_valid  = v;
    in_column = c;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) s += int'(c[i]);
    if (!rst_n) begin
      hist.delete();
      exp_out = '0;
      exp_v   = 1'b0;
      if (v) hist.push_back(s);
    end else if (v) begin
      hist.push_back(s);
      exp_v   = (hist.size() - 1 >= 6);
      exp_out = MB'(moment(hist.size() - 1 - 6));
    end else begin
      exp_v = 1'b0;
    end
    tests++;
    assert (out_valid === exp_v) else begin
      fails++;
      $error("FAIL %s_valid: got %0b expected %0b", tag, out_valid, exp_v);
    end
    tests++;
    assert (out_xmoment === exp_out) else begin
      fails++;
      $error("FAIL %s_moment: got %0d expected %0d", tag, out_xmoment, exp_out);
    end
  endtask

  int ramp[10] = '{1, 2, 3, 5, 6, 7, 8, 1, 0, 0};
  int full[9]  = '{1, 0, 0, 4, 13, 4, 1275, 1275, 1275};
  col_t ff_col;
  col_t sym_col;

  initial begin
    for (int i = 0; i < 5; i++) ff_col[i] = 8'hFF;

    // Reset held with no valid column.
    for (int i = 0; i < 3; i++) step(0, 0, ff_col, "reset_hold");

    // Ramp start, reset concurrent with the first column.
    for (int i = 0; i < 10; i++) step(i != 0, 1, mk_col(ramp[i]), "ramp");
    for (int i = 0; i < 7; i++) step(1, 1, mk_col(0), "ramp_tail");

    // Same stream with stalls after accepted columns 3, 6 and 9.
    for (int i = 0; i < 10; i++) begin
      step(i != 0, 1, mk_col(ramp[i]), "stall_stream");
      if (i == 2 || i == 5 || i == 8) step(1, 0, ff_col, "stall_cycle");
    end
    for (int i = 0; i < 7; i++) begin
      step(1, 1, mk_col(0), "stall_tail");
      step(1, 0, ff_col, "stall_tail_gap");
    end

    // Full-scale columns.
    for (int i = 0; i < 9; i++) step(i != 0, 1, mk_col(full[i]), "fullscale");
    for (int i = 0; i < 10; i++) step(1, 1, mk_col(0), "fullscale_tail");

    // Symmetry: identical columns, then a mirrored ramp.
    sym_col = rnd_col();
    for (int i = 0; i < 13; i++) step(i != 0, 1, sym_col, "symmetry");
    for (int i = 9; i >= 0; i--) step(1, 1, mk_col(ramp[i]), "mirror");
    for (int i = 0; i < 7; i++) step(1, 1, mk_col(0), "mirror_tail");

    // Mid-stream reset with a valid column in the reset cycle.
    for (int i = 0; i < 10; i++) step(1, 1, rnd_col(), "pre_reset");
    step(0, 1, rnd_col(), "midreset");
    for (int i = 0; i < 14; i++) step(1, ($urandom_range(0, 3) != 0), rnd_col(), "post_reset");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0), rnd_col(), "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/x_moment.md
# x_moment

Streaming horizontal first-moment (x-moment) engine for a sliding luma window. Each accepted cycle takes one column of `WINDOW_SIZE_Y` pixels. It produces the signed x-weighted sum of column sums over the last `WINDOW_SIZE_X` accepted columns, with weights −HALF_WIDTH (oldest) … +HALF_WIDTH (newest). It sits in the feature/orientation front end, fed by a column-scanning window buffer.

## Interface
- `LUMA_BITS`, 8, pixel width (unsigned).
- `WINDOW_SIZE_X`, 7, window width in columns (odd).
- `WINDOW_SIZE_Y`, 5, pixels per column.
- Derived values (not overridable):
  - `HALF_WIDTH` = `WINDOW_SIZE_X/2`.
  - `MOMENT_BITS` = `$clog2(HALF_WIDTH*(HALF_WIDTH+1)*WINDOW_SIZE_Y/2) + LUMA_BITS + 1`, which is 14 for the defaults.

Ports:
- `clk`  in  1  sole clock; everything on the rising edge.
- `in_reset`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  column qualifier; the pipeline advances only when high.
- `in_column`  in  `[LUMA_BITS-1:0]` × `WINDOW_SIZE_Y` (unpacked)  incoming pixel column.
- `out_xmoment`  out  signed `MOMENT_BITS`  moment result.
- `out_valid`  out  1  result qualifier.

## Operation
- Column sum: S = Σ `in_column[i]` (unsigned, width `LUMA_BITS+$clog2(WINDOW_SIZE_Y+1)`), computed on accepted columns only.
- Number accepted columns since reset n = 0,1,2…; S(n) is the sum of column n; S(k<0) = 0.
- Moment: M(k) = Σ_{d=1..HALF_WIDTH} d·(S(k−HALF_WIDTH+d) − S(k−HALF_WIDTH−d)).
  - The centre column S(k−HALF_WIDTH) has weight 0.
  - The newest column has weight +HALF_WIDTH; the oldest has weight −HALF_WIDTH.
- Arithmetic is exact in signed `MOMENT_BITS`. No saturation is needed, because the worst case ±HALF_WIDTH·(HALF_WIDTH+1)/2·WINDOW_SIZE_Y·(2^LUMA_BITS−1) fits the width.
- Cycles with `in_valid`=0:
  - The column is ignored.
  - No window, pipeline or output register changes.
  - `out_xmoment` holds its value.
- Reset (`in_reset`=0 at an edge):
  - Column-sum history and all pipeline registers are cleared to zero.
  - `out_xmoment` resets to 0 and `out_valid` to 0.
  - The accepted-column count restarts.
  - If `in_valid`=1 in the same cycle, that column is accepted as column n=0 into the otherwise-cleared state.
- Reset mid-stream discards all in-flight results; subsequent behaviour is identical to a fresh start.
- Recommended structure:
  - Stage 1: adder tree for the column sum.
  - Stage 2: a `WINDOW_SIZE_X`-deep shift register of sums.
  - Then mirrored differences, then constant-weight shift-adds, then a final summation.
  - Every stage is enabled by the accepted column.

## Timing
- Latency is counted in accepted columns, not clock cycles.
- After the edge accepting column n, `out_xmoment` = M(n−6) (defaults; 6 accepted columns of pipeline).
- Stalls (`in_valid`=0) insert no bubbles in the result sequence; results appear strictly in order, one per accepted column.
- `out_valid` is a one-cycle pulse, registered. It is 1 in the cycle after an edge that accepted column n with n−6 ≥ 0 (the pipeline is primed), and 0 otherwise, including after stall cycles.
- The first valid result is M(0), available after the 7th accepted column since reset. It includes the zero-padded pre-reset history.
- No back-pressure: a result must be consumed in the cycle `out_valid`=1.

## Test plan
- Ramp start:
  - Stimulus: reset concurrent with the first column. Columns sums 1,2,3,5,6,7,8,1,0,0 are each accepted (e.g. a column {1,0,0,0,0}).
  - Required response: successive `out_valid` results 3, 8, 14, 23, 30, 34, 34, 9, −15, −33.
- Stall insertion:
  - Stimulus: the same stream with `in_valid`=0 columns (all 0xFF) interleaved after the 3rd, 6th and 9th accepted columns.
  - Required response: an identical result sequence. `out_xmoment` is unchanged and `out_valid`=0 in each cycle following a stall.
- Full-scale:
  - Stimulus: after sums 1,0,0,4,13,4, three columns of all-0xFF (1275 each), then zeros.
  - Required response: results include 3843, 6375, 7629, 3783, −47, −3837, −7650 with no overflow in 14 bits.
- Symmetry:
  - Stimulus: seven identical columns (any value).
  - Required response: result 0. A mirrored ramp gives the negated ramp result.
- Mid-stream reset:
  - Stimulus: assert reset after 10 columns, with `in_valid`=1 in the reset cycle.
  - Required response: `out_valid` stays 0 for the next 6 accepted columns. The results then match the fresh-start sequence for the new stream.
- Reset value:
  - Stimulus: reset held with `in_valid`=0.
  - Required response: `out_xmoment`=0 and `out_valid`=0.
